// File: rtl/data_mem_responder_if.sv
// Load/store bundle between the MEM-stage pipeline register and the data
// memory responder. The pipeline side drives the request fields and the
// responder drives the completion, error, stall and load-data signals.
interface data_mem_responder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  mem_req;
  logic                  mem_rw;
  logic [1:0]            mem_size;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_done;
  logic                  mem_err;
  logic                  mem_busy;

  // Pipeline side: issues requests, consumes results.
  modport master (
    output mem_req, mem_rw, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_done, mem_err, mem_busy
  );

  // Memory side: consumes requests, produces results.
  modport slave (
    input  mem_req, mem_rw, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_done, mem_err, mem_busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory with a fixed access latency.
// One access at a time: IDLE accepts, WAIT counts LATENCY cycles, DONE pulses
// mem_done for one cycle. The RAM is split into four byte lanes (lane k holds
// bytes with addr[1:0]==k) so every legal access touches a single row, and each
// lane is a plain byte array with a registered read.
// Optional feature: define MEM_ROTATE_EN to make misaligned word accesses
// legal (aligned row access, load result rotated right by 8*addr[1:0]).
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  data_mem_responder_if.slave bus
);

  localparam int ROW_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** ROW_W;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic accept;
  logic finish;

  // Captured request; only rewritten on the accepting edge.
  logic                  rw_reg;
  logic [1:0]            size_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg;

  logic [31:0] rdata_reg;
  logic        done_reg;
  logic        err_reg;
  logic        busy_reg;

  logic        acc_err;
  logic [31:0] rd_word;
  logic [31:0] load_val;
  logic [4:0]  lane_shift;
  logic [31:0] shifted;
`ifdef MEM_ROTATE_EN
  logic [63:0] rot_pair;
`endif

  // Next-state logic: accept in IDLE, count down in WAIT, single DONE cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.mem_req) begin
          accept     = 1'b1;
          state_next = S_WAIT;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Request capture; later changes on the bus are ignored until IDLE again.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_reg    <= bus.mem_rw;
      size_reg  <= bus.mem_size;
      addr_reg  <= bus.mem_addr;
      wdata_reg <= bus.mem_wdata;
    end
  end

  // Reject reserved size and misaligned halfword/word accesses.
  always_comb begin
    acc_err = 1'b0;
    unique case (size_reg)
      SZ_HALF: acc_err = addr_reg[0];
`ifdef MEM_ROTATE_EN
      SZ_WORD: acc_err = 1'b0;
`else
      SZ_WORD: acc_err = |addr_reg[1:0];
`endif
      SZ_BYTE: acc_err = 1'b0;
      default: acc_err = 1'b1;
    endcase
  end

  // Four byte lanes. The read of the addressed row is registered on the
  // accepting edge; no write can land in between, so it is still current when
  // the result is formatted at the end of WAIT.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] bank [DEPTH];
      logic [7:0] rd_q;
      logic [7:0] wr_byte;
      logic       lane_sel;
      logic       lane_we;

      // Lane write data: word uses its own byte, halfword the low/high byte.
      assign wr_byte = (size_reg == SZ_WORD) ? wdata_reg[8*gi +: 8] :
                       (size_reg == SZ_HALF) ? wdata_reg[8*(gi%2) +: 8] :
                                               wdata_reg[7:0];

      // Lanes covered by the captured access.
      always_comb begin
        lane_sel = 1'b0;
        unique case (size_reg)
          SZ_BYTE: lane_sel = (addr_reg[1:0] == LANE);
          SZ_HALF: lane_sel = (addr_reg[1] == LANE[1]);
          SZ_WORD: lane_sel = 1'b1;
          default: lane_sel = 1'b0;
        endcase
      end

      // Commit only on the edge entering DONE, never while reset is held.
      assign lane_we = reset_n & finish & rw_reg & ~acc_err & lane_sel;

      // Byte-lane RAM with registered read.
      always_ff @(posedge clk) begin
        if (lane_we) begin
          bank[addr_reg[ADDR_WIDTH-1:2]] <= wr_byte;
        end
        if (accept) begin
          rd_q <= bank[bus.mem_addr[ADDR_WIDTH-1:2]];
        end
      end
    end
  endgenerate

  assign rd_word    = {g_lane[3].rd_q, g_lane[2].rd_q, g_lane[1].rd_q, g_lane[0].rd_q};
  assign lane_shift = {addr_reg[1:0], 3'b000};
  assign shifted    = rd_word >> lane_shift;
`ifdef MEM_ROTATE_EN
  assign rot_pair   = {rd_word, rd_word} >> lane_shift;
`endif

  // Load formatting: zero-extended byte/halfword, word (optionally rotated).
  always_comb begin
    load_val = 32'd0;
    unique case (size_reg)
      SZ_BYTE: load_val = {24'd0, shifted[7:0]};
      SZ_HALF: load_val = {16'd0, shifted[15:0]};
`ifdef MEM_ROTATE_EN
      SZ_WORD: load_val = rot_pair[31:0];
`else
      SZ_WORD: load_val = rd_word;
`endif
      default: load_val = 32'd0;
    endcase
  end

  // Registered outputs: done/err pulse, stall flag, held load data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_reg <= 32'd0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      done_reg <= finish;
      err_reg  <= finish & acc_err;
      busy_reg <= (state_next != S_IDLE);
      if (finish) begin
        if (acc_err) begin
          rdata_reg <= 32'd0;
        end else if (!rw_reg) begin
          rdata_reg <= load_val;
        end
      end
    end
  end

  assign bus.mem_rdata = rdata_reg;
  assign bus.mem_done  = done_reg;
  assign bus.mem_err   = err_reg;
  assign bus.mem_busy  = busy_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of load/store vectors with a scoreboard
// queue, plus hand-written reset-abort and held-request sequences.
module tb_data_mem_responder;

  localparam int AW  = 8;
  localparam int LAT = 2;

  typedef struct {
    string       name;
    bit          rw;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          chk_rd;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    bit          err;
    bit          chk_rd;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  vec_t vecs[$];
  exp_t sb_q[$];

  data_mem_responder_if #(.ADDR_WIDTH(AW)) bus ();

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input bit rw, input logic [1:0] size,
                     input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input bit exp_err, input bit chk_rd);
    vec_t v;
    v.name = name; v.rw = rw; v.size = size; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.chk_rd = chk_rd;
    vecs.push_back(v);
  endtask

  // Waits for mem_done after an accept, checking latency, stall length and
  // that mem_err stays low outside done; then checks the return to IDLE.
  task automatic wait_done(input bit scramble);
    int   edges;
    int   busy_cnt;
    bit   seen;
    exp_t e;
    edges    = 0;
    busy_cnt = 1;
    seen     = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (scramble) begin
        @(negedge clk);
        bus.mem_addr = 8'($urandom_range(0, 255));
      end
      @(posedge clk);
      #1;
      edges++;
      if (bus.mem_busy) busy_cnt++;
      if (bus.mem_done) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          $display("txn %s: rdata=%h err=%0b edges=%0d", e.name, bus.mem_rdata, bus.mem_err, edges);
          if (e.chk_rd) check({e.name, "_rdata"}, bus.mem_rdata, e.rdata);
          check({e.name, "_err"}, 32'(bus.mem_err), 32'(e.err));
          check({e.name, "_latency"}, 32'(edges), 32'(LAT));
          check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(LAT + 1));
        end
      end else if (bus.mem_err) begin
        check("err_without_done", 32'(bus.mem_err), 32'd0);
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
      check("idle_after_done", 32'(bus.mem_busy), 32'd0);
    end
  endtask

  // Drives one request at a negedge, pushes its expectation, and checks the
  // accepting edge raised busy.
  task automatic issue(input vec_t v, input bit hold, input bit scramble);
    exp_t e;
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_rw    = v.rw;
    bus.mem_size  = v.size;
    bus.mem_addr  = v.addr;
    bus.mem_wdata = v.wdata;
    e.name = v.name; e.rdata = v.exp_rdata; e.err = v.exp_err; e.chk_rd = v.chk_rd;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check({v.name, "_accept_busy"}, 32'(bus.mem_busy), 32'd1);
    if (!hold) bus.mem_req = 1'b0;
    wait_done(scramble);
  endtask

  initial begin
    vec_t v;
    int   done_cnt;
    total = 0;
    bad   = 0;
    reset_n       = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.mem_size  = 2'b00;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", bus.mem_rdata, 32'd0);
    check("rst_done", 32'(bus.mem_done), 32'd0);
    check("rst_err", 32'(bus.mem_err), 32'd0);
    check("rst_busy", 32'(bus.mem_busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    //   name       rw  size   addr   wdata          exp_rdata      err chk
    add("st_w10",   1, 2'b00, 8'h10, 32'hDEADBEEF, 32'h0,         0, 0);
    add("ld_w10",   0, 2'b00, 8'h10, 32'h0,        32'hDEADBEEF,  0, 1);
    add("ld_b11",   0, 2'b10, 8'h11, 32'h0,        32'h000000BE,  0, 1);
    add("ld_b13",   0, 2'b10, 8'h13, 32'h0,        32'h000000DE,  0, 1);
    add("st_b12",   1, 2'b10, 8'h12, 32'h123456AA, 32'h0,         0, 0);
    add("ld_w10b",  0, 2'b00, 8'h10, 32'h0,        32'hDEAABEEF,  0, 1);
    add("ld_h12",   0, 2'b01, 8'h12, 32'h0,        32'h0000DEAA,  0, 1);
`ifdef MEM_ROTATE_EN
    add("ld_w11",   0, 2'b00, 8'h11, 32'h0,        32'hEFDEAABE,  0, 1);
`else
    add("ld_w11",   0, 2'b00, 8'h11, 32'h0,        32'h0,         1, 1);
`endif
    add("ld_w10c",  0, 2'b00, 8'h10, 32'h0,        32'hDEAABEEF,  0, 1);
    add("ld_h13",   0, 2'b01, 8'h13, 32'h0,        32'h0,         1, 1);
    add("st_w20",   1, 2'b00, 8'h20, 32'hCAFEF00D, 32'h0,         0, 0);
    add("st_s3_20", 1, 2'b11, 8'h20, 32'h11111111, 32'h0,         1, 1);
    add("ld_w20",   0, 2'b00, 8'h20, 32'h0,        32'hCAFEF00D,  0, 1);
    add("st_h22",   1, 2'b01, 8'h22, 32'hFFFF1234, 32'h0,         0, 0);
    add("ld_w20b",  0, 2'b00, 8'h20, 32'h0,        32'h1234F00D,  0, 1);
    add("st_h21",   1, 2'b01, 8'h21, 32'hFFFFFFFF, 32'h0,         1, 1);
    add("ld_w20c",  0, 2'b00, 8'h20, 32'h0,        32'h1234F00D,  0, 1);
    add("st_w40",   1, 2'b00, 8'h40, 32'h00000000, 32'h0,         0, 0);
`ifdef MEM_ROTATE_EN
    add("st_w41",   1, 2'b00, 8'h41, 32'h55667788, 32'h0,         0, 0);
    add("ld_w40",   0, 2'b00, 8'h40, 32'h0,        32'h55667788,  0, 1);
`else
    add("st_w41",   1, 2'b00, 8'h41, 32'h55667788, 32'h0,         1, 1);
    add("ld_w40",   0, 2'b00, 8'h40, 32'h0,        32'h00000000,  0, 1);
`endif
    add("st_w30",   1, 2'b00, 8'h30, 32'h0BADF00D, 32'h0,         0, 0);
    add("ld_w30",   0, 2'b00, 8'h30, 32'h0,        32'h0BADF00D,  0, 1);

    foreach (vecs[i]) issue(vecs[i], 1'b0, 1'b0);

    // Store aborted by reset during WAIT: outputs clear, store is dropped.
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_rw    = 1'b1;
    bus.mem_size  = 2'b00;
    bus.mem_addr  = 8'h30;
    bus.mem_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    check("abort_accept_busy", 32'(bus.mem_busy), 32'd1);
    bus.mem_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_rdata", bus.mem_rdata, 32'd0);
    check("abort_busy", 32'(bus.mem_busy), 32'd0);
    check("abort_done", 32'(bus.mem_done), 32'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_done || bus.mem_busy) done_cnt++;
    end
    check("abort_no_activity", 32'(done_cnt), 32'd0);
    add("ld_w30_after_abort", 0, 2'b00, 8'h30, 32'h0, 32'h0BADF00D, 0, 1);
    issue(vecs[vecs.size()-1], 1'b0, 1'b0);

    // Request held with a wandering address: only the captured one is used,
    // and the held request is taken again on the first IDLE edge.
    add("held_w10", 0, 2'b00, 8'h10, 32'h0, 32'hDEAABEEF, 0, 1);
    issue(vecs[vecs.size()-1], 1'b1, 1'b1);
    add("held_w20", 0, 2'b00, 8'h20, 32'h0, 32'h1234F00D, 0, 1);
    v = vecs[vecs.size()-1];
    @(negedge clk);
    bus.mem_addr = v.addr;
    begin
      exp_t e;
      e.name = v.name; e.rdata = v.exp_rdata; e.err = v.exp_err; e.chk_rd = v.chk_rd;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("held_reaccept_busy", 32'(bus.mem_busy), 32'd1);
    bus.mem_req = 1'b0;
    wait_done(1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
